// File: rtl/bp_table_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bp_table_ctrl_pkg
// Brief    : Shared encodings for the branch pattern table controller:
//            2-bit saturating counter values and controller FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package bp_table_ctrl_pkg;

    // 2-bit saturating counter encodings
    localparam logic [1:0] c_snt      = 2'b00;  // strongly not-taken
    localparam logic [1:0] c_wnt      = 2'b01;  // weakly not-taken
    localparam logic [1:0] c_wt       = 2'b10;  // weakly taken
    localparam logic [1:0] c_st       = 2'b11;  // strongly taken
    localparam logic [1:0] c_init_val = c_wnt;  // value written by the init sweep

    // Controller states, explicitly encoded
    typedef enum logic [2:0] {
        S_INIT      = 3'd0,
        S_IDLE      = 3'd1,
        S_PRED_WAIT = 3'd2,
        S_UPD_WAIT  = 3'd3,
        S_UPD_WR    = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bp_table_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : bp_table_ctrl_if
// Brief    : Bundles the prediction, resolution, table and history signals of
//            the BPT controller. The controller takes the slave view; the
//            fetch/execute/table side takes the master view.
// Revision : 1.0 - initial release
// ============================================================================
interface bp_table_ctrl_if #(
    parameter int HIST_BITS = 4
);
    // fetch-side prediction handshake
    logic                 pred_req;
    logic                 pred_ready;
    logic                 pred_valid;
    logic                 pred_taken;
    logic [HIST_BITS-1:0] pred_index;
    // execute-side resolution handshake
    logic                 resolve_valid;
    logic                 resolve_ready;
    logic [HIST_BITS-1:0] resolve_index;
    logic                 resolve_taken;
    // single-port synchronous-read table
    logic [HIST_BITS-1:0] tbl_addr;
    logic                 tbl_we;
    logic [1:0]           tbl_wdata;
    logic [1:0]           tbl_rdata;
    // history observability
    logic [HIST_BITS-1:0] bhr;

    modport master (
        output pred_req, resolve_valid, resolve_index, resolve_taken, tbl_rdata,
        input  pred_ready, pred_valid, pred_taken, pred_index, resolve_ready,
               tbl_addr, tbl_we, tbl_wdata, bhr
    );

    modport slave (
        input  pred_req, resolve_valid, resolve_index, resolve_taken, tbl_rdata,
        output pred_ready, pred_valid, pred_taken, pred_index, resolve_ready,
               tbl_addr, tbl_we, tbl_wdata, bhr
    );
endinterface
`default_nettype wire

// File: rtl/bp_update_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bp_update_fifo
// Brief    : Small synchronous FIFO holding pending branch resolutions
//            ({index, taken}). Push while full and pop while empty are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module bp_update_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] push_data,
    input  wire logic             pop,
    output logic                  full,
    output logic                  empty,
    output logic [WIDTH-1:0]      head
);
    localparam int                c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]  c_full  = (c_ptr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_push;
    logic               w_pop;

    // full/empty come from the registered count only
    assign full   = (r_count == c_full);
    assign empty  = (r_count == '0);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign head   = r_mem[r_rd_ptr];

    // Storage array: written on accepted push, no reset needed
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; simultaneous push/pop keeps count
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bp_table_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bp_table_ctrl
// Brief    : Branch pattern table controller. Initialises the table after
//            reset, serves prediction lookups, and retires buffered branch
//            resolutions as read-modify-write sequences while maintaining a
//            non-speculative global history register.
// Revision : 1.0 - initial release
// ============================================================================
module bp_table_ctrl
    import bp_table_ctrl_pkg::*;
#(
    parameter int HIST_BITS = 4,
    parameter int UPD_DEPTH = 4
) (
    input  wire logic      clock,
    input  wire logic      reset,
    bp_table_ctrl_if.slave bus
);
    localparam int                   c_fifo_w    = HIST_BITS + 1;
    localparam logic [HIST_BITS-1:0] c_init_last = '1;

    state_t               r_state;
    logic [HIST_BITS-1:0] r_bhr;
    logic [HIST_BITS-1:0] r_init_cnt;
    logic [HIST_BITS-1:0] r_idx_q;
    logic [1:0]           r_cnt_q;

    logic                 w_full;
    logic                 w_empty;
    logic [c_fifo_w-1:0]  w_head;
    logic [HIST_BITS-1:0] w_head_index;
    logic                 w_head_taken;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_pred_ready;
    logic                 w_pred_acc;
    logic                 w_upd_read;
    logic [1:0]           w_cnt_next;

    assign w_head_index = w_head[HIST_BITS:1];
    assign w_head_taken = w_head[0];
    assign w_push       = bus.resolve_valid && bus.resolve_ready;
    assign w_pop        = (r_state == S_UPD_WR);

    bp_update_fifo #(
        .DEPTH (UPD_DEPTH),
        .WIDTH (c_fifo_w)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data ({bus.resolve_index, bus.resolve_taken}),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head)
    );

    // IDLE arbitration: a full FIFO beats predictions, predictions beat a
    // partially filled FIFO so fetch is never starved by trickling updates
    assign w_pred_ready = !reset && (r_state == S_IDLE) && !w_full;
    assign w_pred_acc   = bus.pred_req && w_pred_ready;
    assign w_upd_read   = (r_state == S_IDLE) && (w_full || (!w_pred_acc && !w_empty));

    // Saturating counter step toward the resolved direction, no wrap
    always_comb begin
        w_cnt_next = r_cnt_q;
        if (w_head_taken && (r_cnt_q != c_st)) begin
            w_cnt_next = r_cnt_q + 2'b01;
        end else if (!w_head_taken && (r_cnt_q != c_snt)) begin
            w_cnt_next = r_cnt_q - 2'b01;
        end
    end

    // Output decode from state; reset forces every strobe low immediately
    always_comb begin
        bus.pred_ready    = w_pred_ready;
        bus.resolve_ready = !reset && !w_full;
        bus.pred_valid    = 1'b0;
        bus.pred_taken    = 1'b0;
        bus.pred_index    = r_idx_q;
        bus.tbl_addr      = r_bhr;
        bus.tbl_we        = 1'b0;
        bus.tbl_wdata     = c_init_val;
        bus.bhr           = reset ? '0 : r_bhr;
        case (r_state)
            S_INIT: begin
                bus.tbl_addr  = r_init_cnt;
                bus.tbl_we    = !reset;
                bus.tbl_wdata = c_init_val;
            end
            S_IDLE: begin
                bus.tbl_addr = w_upd_read ? w_head_index : r_bhr;
            end
            S_PRED_WAIT: begin
                bus.pred_valid = !reset;
                bus.pred_taken = !reset && bus.tbl_rdata[1];
            end
            S_UPD_WAIT: begin
                bus.tbl_addr = w_head_index;
            end
            S_UPD_WR: begin
                bus.tbl_addr  = w_head_index;
                bus.tbl_we    = !reset;
                bus.tbl_wdata = w_cnt_next;
            end
            default: begin
            end
        endcase
    end

    // Controller FSM with history, init counter and RMW capture registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_INIT;
            r_bhr      <= '0;
            r_init_cnt <= '0;
            r_idx_q    <= '0;
            r_cnt_q    <= c_snt;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (r_init_cnt == c_init_last) begin
                        r_state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (w_upd_read) begin
                        r_state <= S_UPD_WAIT;
                    end else if (w_pred_acc) begin
                        r_idx_q <= r_bhr;
                        r_state <= S_PRED_WAIT;
                    end
                end
                S_PRED_WAIT: begin
                    r_state <= S_IDLE;
                end
                S_UPD_WAIT: begin
                    r_cnt_q <= bus.tbl_rdata;
                    r_state <= S_UPD_WR;
                end
                S_UPD_WR: begin
                    r_bhr   <= {r_bhr[HIST_BITS-2:0], w_head_taken};
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/bp_table_ctrl.md
Name: bp_table_ctrl

Overview:
Controller for the branch pattern table (BPT) of 2-bit saturating counters. It owns the global branch history register (BHR) and performs the post-reset table initialisation sweep. It arbitrates the single-port, synchronous-read BPT between fetch-stage prediction lookups and execute-stage resolution updates. Resolutions are buffered in a small FIFO and retired as read-modify-write sequences.

Parameters:
HIST_BITS, 4, BHR width; BPT holds 2^HIST_BITS entries
UPD_DEPTH, 4, resolution FIFO depth (power of 2, >=2)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high
pred_req  input  1  fetch requests a prediction
pred_ready  output  1  controller can accept pred_req this cycle
pred_valid  output  1  pred_taken/pred_index valid (one-cycle pulse)
pred_taken  output  1  predicted direction (counter MSB)
pred_index  output  HIST_BITS  BPT index used (BHR at accept)
resolve_valid  input  1  execute reports a resolved branch
resolve_ready  output  1  FIFO not full
resolve_index  input  HIST_BITS  index returned from pred_index
resolve_taken  input  1  actual outcome
tbl_addr  output  HIST_BITS  BPT address
tbl_we  output  1  BPT write enable
tbl_wdata  output  2  BPT write data
tbl_rdata  input  2  BPT read data, valid the cycle after address presented with tbl_we=0
bhr  output  HIST_BITS  current history (debug/observability)

Behaviour:
- Reset is synchronous and active-high; clock is "clock", reset is "reset".
- While reset is high: pred_valid=0, pred_ready=0, resolve_ready=0, tbl_we=0, bhr=0.
- Reset also flushes the FIFO and zeroes init_cnt.
- First cycle after reset deasserts: state=INIT. Reset asserted in any state aborts all activity, including a half-done RMW (no write issued).
- States: INIT, IDLE, PRED_WAIT, UPD_WAIT, UPD_WR.
- INIT:
  - tbl_we=1, tbl_addr=init_cnt, tbl_wdata=2'b01 (weakly not-taken); init_cnt++.
  - When init_cnt == 2^HIST_BITS-1, go to IDLE. Exactly 2^HIST_BITS cycles.
  - pred_ready=0 throughout. resolve_ready follows FIFO state, so enqueue is allowed.
- pred_ready = (state==IDLE) && !fifo_full.
- IDLE, priority order:
  1) fifo_full: issue update read, tbl_addr=head.index, go to UPD_WAIT.
  2) pred_req && pred_ready: tbl_addr=bhr, latch bhr into idx_q, go to PRED_WAIT.
  3) fifo nonempty: update read as in (1).
  4) else stay. tbl_addr=bhr, tbl_we=0.
- PRED_WAIT: pred_valid=1, pred_taken=tbl_rdata[1], pred_index=idx_q; go to IDLE.
  - Latency: accept at cycle N, result at N+1. Next accept no earlier than N+2.
- UPD_WAIT: register cnt_q=tbl_rdata; go to UPD_WR.
- UPD_WR:
  - tbl_we=1, tbl_addr=head.index, tbl_wdata=next(cnt_q, head.taken).
  - Pop FIFO; bhr <= {bhr[HIST_BITS-2:0], head.taken}; go to IDLE.
  - RMW occupies the table 3 cycles.
- Counter update:
  - taken && cnt!=2'b11 -> cnt+1.
  - !taken && cnt!=2'b00 -> cnt-1.
  - Otherwise hold. No wrap at either end.
- pred_valid=0 and tbl_we=0 in all states and cycles not listed above.
- BHR is non-speculative: it changes only in UPD_WR, in FIFO order.
- FIFO:
  - Enqueue when resolve_valid && resolve_ready; resolve_ready = !fifo_full.
  - A pop in the same cycle does not make a full FIFO accept; ready is based on the registered count.
  - Simultaneous enqueue and pop when not full: count unchanged, both take effect.
- No forwarding: a prediction read of an index with a queued or in-flight update returns the pre-update table value.
- Full-FIFO priority guarantees forward progress of updates. With an empty FIFO, predictions are never starved.

Decomposition:
- Shared package:
  - Counter encodings: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - INIT_VAL=WNT.
  - FSM state encodings.
- Sub-module bp_update_fifo: synchronous FIFO, UPD_DEPTH x (HIST_BITS+1).
  - Ports: push, pop, full, empty, head data.
  - Same clock/reset convention.
- Counter next-value logic stays inline.

Test Plan:
- Reset release, HIST_BITS=4 -> 16 consecutive cycles of tbl_we=1 with addr 0..15, wdata=01. pred_ready=0 throughout, rises on cycle 17.
- After init, pred_req held 1 -> pred_valid every 2nd cycle, pred_index=0, pred_taken=0. Table model entry 0 reads 01.
- Enqueue resolve(index=3, taken=1) twice -> two RMWs, entry 3 goes 01->10->11, bhr goes 0000->0001->0011. A third taken resolve writes 11 (saturation hold).
- Resolve(index=5, taken=0) on entry already 00 -> writes 00, no wrap to 11. bhr shifts in 0.
- Fill FIFO with 4 resolves while pred_req=1 -> resolve_ready=0 and pred_ready=0. Next IDLE issues an update read, not a prediction. pred_ready returns once count=3.
- Assert reset during UPD_WAIT -> no tbl_we in the following cycle. FIFO empty, bhr=0, INIT restarts at addr 0.
